// File: rtl/audio_stereo_sample_bridge_if.sv
// DSP-side stream bundle for the stereo bridge: TX pair writes in, RX pair reads out.
// Valid/ready: a transfer happens on a clock edge where valid and ready are both 1.
interface audio_stereo_sample_bridge_if;
  logic [23:0] tx_left_i;
  logic [23:0] tx_right_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [23:0] rx_left_o;
  logic [23:0] rx_right_o;
  logic        rx_valid_o;
  logic        rx_ready_i;

  modport master (
    output tx_left_i, tx_right_i, tx_valid_i, rx_ready_i,
    input  tx_ready_o, rx_left_o, rx_right_o, rx_valid_o
  );

  modport slave (
    input  tx_left_i, tx_right_i, tx_valid_i, rx_ready_i,
    output tx_ready_o, rx_left_o, rx_right_o, rx_valid_o
  );
endinterface

// File: rtl/audio_stereo_sample_bridge.sv
// Stereo sample bridge: pairs ADC slot words into an RX FIFO and feeds DAC slot
// words from a TX FIFO of DSP-written pairs, driven by sample-clock edges.
module audio_stereo_sample_bridge #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         sample_clk_i,
  input  logic [23:0]                  adc_parallel_data_i,
  output logic [23:0]                  dac_parallel_data_o,
  audio_stereo_sample_bridge_if.slave  bus,
  output logic [LW-1:0]                rx_level_o,
  output logic [LW-1:0]                tx_level_o,
  output logic                         rx_overflow_o,
  output logic                         tx_underrun_o,
  input  logic                         clear_i
);

  logic          sc_q;
  logic          rise;
  logic          fall;
  logic [23:0]   left_hold;
  logic [23:0]   right_hold;
  logic          left_ok;

  logic [47:0]   rx_mem [DEPTH];
  logic [47:0]   tx_mem [DEPTH];
  logic [PW-1:0] rx_wr;
  logic [PW-1:0] rx_rd;
  logic [PW-1:0] tx_wr;
  logic [PW-1:0] tx_rd;

  logic          rx_full;
  logic          rx_empty;
  logic          tx_full;
  logic          tx_empty;
  logic          rx_push_req;
  logic          rx_push;
  logic          rx_pop;
  logic          tx_push;
  logic          tx_pop;

  // sc_q tracks even while disabled so re-enabling never sees a stale edge
  assign rise = en_i & sample_clk_i & ~sc_q;
  assign fall = en_i & ~sample_clk_i & sc_q;

  assign rx_full  = (rx_level_o == LW'(DEPTH));
  assign rx_empty = (rx_level_o == '0);
  assign tx_full  = (tx_level_o == LW'(DEPTH));
  assign tx_empty = (tx_level_o == '0);

  // Fullness is judged on start-of-cycle occupancy, so a same-cycle pop never rescues a push
  assign rx_push_req = rise & left_ok;
  assign rx_push     = rx_push_req & ~rx_full;
  assign rx_pop      = bus.rx_valid_o & bus.rx_ready_i;
  assign tx_push     = bus.tx_valid_i & bus.tx_ready_o;
  assign tx_pop      = rise & ~tx_empty;

  assign bus.tx_ready_o = ~tx_full & ~rst_i;
  assign bus.rx_valid_o = ~rx_empty;

  always_comb begin
    bus.rx_left_o  = '0;
    bus.rx_right_o = '0;
    if (!rx_empty) begin
      bus.rx_left_o  = rx_mem[rx_rd][47:24];
      bus.rx_right_o = rx_mem[rx_rd][23:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr] <= {left_hold, adc_parallel_data_i};
    if (tx_push) tx_mem[tx_wr] <= {bus.tx_left_i, bus.tx_right_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sc_q                <= 1'b0;
      left_hold           <= '0;
      left_ok             <= 1'b0;
      right_hold          <= '0;
      dac_parallel_data_o <= '0;
      rx_wr               <= '0;
      rx_rd               <= '0;
      tx_wr               <= '0;
      tx_rd               <= '0;
      rx_level_o          <= '0;
      tx_level_o          <= '0;
      rx_overflow_o       <= 1'b0;
      tx_underrun_o       <= 1'b0;
    end else begin
      sc_q <= sample_clk_i;

      if (fall) begin
        left_hold <= adc_parallel_data_i;
        left_ok   <= 1'b1;
      end else if (rise) begin
        left_ok <= 1'b0;
      end

      // Underrun still advances the slot with zeros, keeping left/right alignment
      if (rise) begin
        if (tx_empty) begin
          dac_parallel_data_o <= '0;
          right_hold          <= '0;
        end else begin
          dac_parallel_data_o <= tx_mem[tx_rd][47:24];
          right_hold          <= tx_mem[tx_rd][23:0];
        end
      end else if (fall) begin
        dac_parallel_data_o <= right_hold;
      end

      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      rx_level_o <= rx_level_o + LW'(rx_push) - LW'(rx_pop);
      tx_level_o <= tx_level_o + LW'(tx_push) - LW'(tx_pop);

      // Set beats clear when both land on the same edge
      rx_overflow_o <= (rx_overflow_o & ~clear_i) | (rx_push_req & rx_full);
      tx_underrun_o <= (tx_underrun_o & ~clear_i) | (rise & tx_empty);
    end
  end

endmodule

// File: tb/tb_audio_stereo_sample_bridge.sv
// Bench for audio_stereo_sample_bridge: directed steps plus random traffic,
// every cycle compared against a queue-based model of the bridge.
module tb_audio_stereo_sample_bridge;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          en_i = 1'b0;
  logic          sample_clk_i = 1'b0;
  logic [23:0]   adc_parallel_data_i = '0;
  logic [23:0]   dac_parallel_data_o;
  logic [LW-1:0] rx_level_o;
  logic [LW-1:0] tx_level_o;
  logic          rx_overflow_o;
  logic          tx_underrun_o;
  logic          clear_i = 1'b0;

  audio_stereo_sample_bridge_if bus ();

  audio_stereo_sample_bridge #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .en_i                (en_i),
    .sample_clk_i        (sample_clk_i),
    .adc_parallel_data_i (adc_parallel_data_i),
    .dac_parallel_data_o (dac_parallel_data_o),
    .bus                 (bus),
    .rx_level_o          (rx_level_o),
    .tx_level_o          (tx_level_o),
    .rx_overflow_o       (rx_overflow_o),
    .tx_underrun_o       (tx_underrun_o),
    .clear_i             (clear_i)
  );

  // clock/reset
  always #5 clk_i = ~clk_i;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // reference model state
  logic [47:0] rx_q[$];
  logic [47:0] tx_q[$];
  logic        m_sc;
  logic        m_left_ok;
  logic [23:0] m_left_hold;
  logic [23:0] m_rh;
  logic [23:0] m_dac;
  logic        m_ovf;
  logic        m_unr;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s got=%h exp=%h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    m_sc = 1'b0; m_left_ok = 1'b0; m_left_hold = '0;
    m_rh = '0; m_dac = '0; m_ovf = 1'b0; m_unr = 1'b0;
  endtask

  task automatic model_step();
    bit rise, fall;
    int rxn, txn;
    logic [47:0] pair;
    if (rst_i) begin
      model_reset();
      return;
    end
    rise = en_i && sample_clk_i && !m_sc;
    fall = en_i && !sample_clk_i && m_sc;
    m_sc = sample_clk_i;
    rxn  = rx_q.size();
    txn  = tx_q.size();
    if (clear_i) begin m_ovf = 1'b0; m_unr = 1'b0; end
    if (bus.rx_ready_i && rxn > 0) void'(rx_q.pop_front());
    if (fall) begin
      m_left_hold = adc_parallel_data_i;
      m_left_ok   = 1'b1;
    end
    if (rise && m_left_ok) begin
      if (rxn < DEPTH) rx_q.push_back({m_left_hold, adc_parallel_data_i});
      else m_ovf = 1'b1;
      m_left_ok = 1'b0;
    end
    if (rise) begin
      if (txn > 0) begin
        pair  = tx_q.pop_front();
        m_dac = pair[47:24];
        m_rh  = pair[23:0];
      end else begin
        m_dac = '0; m_rh = '0; m_unr = 1'b1;
      end
    end else if (fall) begin
      m_dac = m_rh;
    end
    if (bus.tx_valid_i && txn < DEPTH) tx_q.push_back({bus.tx_left_i, bus.tx_right_i});
  endtask

  // scoreboard comparison of every observable output against the model
  task automatic check_all();
    logic [47:0] head;
    head = (rx_q.size() > 0) ? rx_q[0] : 48'h0;
    chk("dac",      48'(dac_parallel_data_o), 48'(m_dac));
    chk("rx_valid", 48'(bus.rx_valid_o),      48'(rx_q.size() > 0));
    chk("rx_left",  48'(bus.rx_left_o),       48'(head[47:24]));
    chk("rx_right", 48'(bus.rx_right_o),      48'(head[23:0]));
    chk("rx_level", 48'(rx_level_o),          48'(rx_q.size()));
    chk("tx_level", 48'(tx_level_o),          48'(tx_q.size()));
    chk("rx_ovf",   48'(rx_overflow_o),       48'(m_ovf));
    chk("tx_unr",   48'(tx_underrun_o),       48'(m_unr));
    chk("tx_ready", 48'(bus.tx_ready_o),      48'((tx_q.size() < DEPTH) && !rst_i));
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
    check_all();
  endtask

  // driver tasks
  task automatic tx_write(input logic [23:0] l, input logic [23:0] r);
    bus.tx_left_i  = l;
    bus.tx_right_i = r;
    bus.tx_valid_i = 1'b1;
    cycle();
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic slot(input logic sc, input logic [23:0] adc);
    sample_clk_i        = sc;
    adc_parallel_data_i = adc;
    cycle();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    model_reset();
    cycle();
    cycle();
    rst_i = 1'b0;
  endtask

  logic [23:0] fl [DEPTH+1];
  logic [23:0] fr [DEPTH+1];
  logic [LW-1:0] saved_rx, saved_tx;

  initial begin
    bus.tx_left_i = '0; bus.tx_right_i = '0; bus.tx_valid_i = 1'b0; bus.rx_ready_i = 1'b0;
    model_reset();
    #1;

    phase = "reset";
    do_reset();
    chk("rst_dac", 48'(dac_parallel_data_o), 48'h0);
    en_i = 1'b1;
    cycle();
    chk("rst_ready", 48'(bus.tx_ready_o), 48'h1);

    phase = "tx_basic";
    tx_write(24'h111111, 24'h222222);
    tx_write(24'h333333, 24'h444444);
    chk("lvl2", 48'(tx_level_o), 48'd2);
    slot(1'b1, 24'h0); chk("d0", 48'(dac_parallel_data_o), 48'h111111);
    slot(1'b0, 24'h0); chk("d1", 48'(dac_parallel_data_o), 48'h222222);
    slot(1'b1, 24'h0); chk("d2", 48'(dac_parallel_data_o), 48'h333333);
    slot(1'b0, 24'h0); chk("d3", 48'(dac_parallel_data_o), 48'h444444);
    chk("no_unr", 48'(tx_underrun_o), 48'h0);

    phase = "tx_underrun";
    slot(1'b1, 24'h0);
    chk("unr_dac", 48'(dac_parallel_data_o), 48'h0);
    chk("unr_set", 48'(tx_underrun_o), 48'h1);
    slot(1'b0, 24'h0);
    chk("unr_fall", 48'(dac_parallel_data_o), 48'h0);
    clear_i = 1'b1; cycle(); clear_i = 1'b0;
    chk("unr_clr", 48'(tx_underrun_o), 48'h0);

    phase = "rx_pair";
    do_reset();
    slot(1'b1, 24'hAAAAAA);
    chk("first_rise", 48'(bus.rx_valid_o), 48'h0);
    slot(1'b0, 24'h123456);
    slot(1'b1, 24'h654321);
    chk("pair_v", 48'(bus.rx_valid_o), 48'h1);
    chk("pair_l", 48'(bus.rx_left_o), 48'h123456);
    chk("pair_r", 48'(bus.rx_right_o), 48'h654321);
    bus.rx_ready_i = 1'b1; cycle(); bus.rx_ready_i = 1'b0;

    phase = "rx_overflow";
    for (int i = 0; i <= DEPTH; i++) begin
      fl[i] = 24'($urandom);
      fr[i] = 24'($urandom);
      slot(1'b0, fl[i]);
      slot(1'b1, fr[i]);
    end
    chk("ovf_lvl", 48'(rx_level_o), 48'd8);
    chk("ovf_flag", 48'(rx_overflow_o), 48'h1);
    bus.rx_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain", {bus.rx_left_o, bus.rx_right_o}, {fl[i], fr[i]});
      cycle();
    end
    bus.rx_ready_i = 1'b0;
    chk("drained", 48'(bus.rx_valid_o), 48'h0);

    phase = "full_wrap";
    do_reset();
    sample_clk_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) tx_write(24'($urandom), 24'($urandom));
    chk("full_rdy", 48'(bus.tx_ready_o), 48'h0);
    chk("full_lvl", 48'(tx_level_o), 48'd8);
    for (int i = 0; i < 7; i++) slot(~sample_clk_i, 24'($urandom));
    slot(1'b0, 24'($urandom));
    chk("lvl4", 48'(tx_level_o), 48'd4);
    bus.tx_left_i = 24'($urandom); bus.tx_right_i = 24'($urandom); bus.tx_valid_i = 1'b1;
    slot(1'b1, 24'($urandom));
    chk("lvl4_simul", 48'(tx_level_o), 48'd4);
    bus.rx_ready_i = 1'b1;
    for (int i = 0; i < 44; i++) begin
      bus.tx_left_i  = 24'($urandom);
      bus.tx_right_i = 24'($urandom);
      bus.tx_valid_i = ($urandom_range(0, 3) != 0);
      slot(~sample_clk_i, 24'($urandom));
    end
    bus.tx_valid_i = 1'b0;
    bus.rx_ready_i = 1'b0;

    phase = "enable";
    clear_i = 1'b1; cycle(); clear_i = 1'b0;
    tx_write(24'h0ABCDE, 24'h0FEDCB);
    saved_rx = rx_level_o;
    saved_tx = tx_level_o;
    en_i = 1'b0;
    for (int i = 0; i < 6; i++) slot(~sample_clk_i, 24'($urandom));
    chk("en_rx", 48'(rx_level_o), 48'(saved_rx));
    chk("en_tx", 48'(tx_level_o), 48'(saved_tx));
    chk("en_unr", 48'(tx_underrun_o), 48'h0);
    en_i = 1'b1;
    cycle();

    phase = "random";
    for (int i = 0; i < 300; i++) begin
      en_i           = ($urandom_range(0, 9) != 0);
      bus.tx_left_i  = 24'($urandom);
      bus.tx_right_i = 24'($urandom);
      bus.tx_valid_i = $urandom_range(0, 1);
      bus.rx_ready_i = ($urandom_range(0, 2) == 0);
      clear_i        = ($urandom_range(0, 19) == 0);
      slot(($urandom_range(0, 2) == 0) ? sample_clk_i : ~sample_clk_i, 24'($urandom));
    end
    clear_i = 1'b0;

    phase = "mid_reset";
    for (int i = 0; i < 4; i++) tx_write(24'($urandom), 24'($urandom));
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("mr_dac", 48'(dac_parallel_data_o), 48'h0);
    chk("mr_txl", 48'(tx_level_o), 48'h0);
    chk("mr_rxl", 48'(rx_level_o), 48'h0);
    chk("mr_rdy", 48'(bus.tx_ready_o), 48'h0);
    check_all();
    cycle();
    rst_i = 1'b0;
    en_i = 1'b1;
    slot(1'b0, 24'h0);
    slot(1'b1, 24'h777777);
    chk("mr_nopush", 48'(rx_level_o), 48'h0);
    slot(1'b0, 24'h135790);
    slot(1'b1, 24'h246802);
    chk("mr_push", {bus.rx_left_o, bus.rx_right_o}, 48'h135790246802);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_stereo_sample_bridge.md
# audio_stereo_sample_bridge

Stereo sample bridge between the codec serializer (24-bit right-justified buffer) and the DSP side. It captures each ADC word on the serializer's sample-clock edges, pairs left/right words and queues them in an RX FIFO with a valid/ready output. It also pops stereo pairs from a TX FIFO, written by the DSP, and presents each channel word on `dac_parallel_data_o` for the slot that is starting. It sits directly beside the serializer: its `adc_parallel_data_i`/`sample_clk_i` come from that block, and its `dac_parallel_data_o` feeds it.

## Interface
- `DEPTH`, 8, entries per FIFO (power of 2, ≥2); `LW = $clog2(DEPTH)+1`
- `clk_i` in 1 — serializer clock (12 MHz)
- `rst_i` in 1 — asynchronous, active-high reset
- `en_i` in 1 — enables slot capture/pop; handshake ports always active
- `sample_clk_i` in 1 — serializer sample clock; high = left slot, low = right slot
- `adc_parallel_data_i` in 24 — word from serializer SIPO
- `dac_parallel_data_o` out 24 — word for serializer PISO
- `tx_left_i`, `tx_right_i` in 24 each — DSP stereo pair
- `tx_valid_i` in 1 / `tx_ready_o` out 1 — TX write handshake
- `rx_left_o`, `rx_right_o` out 24 each — head RX pair (first-word-fall-through)
- `rx_valid_o` out 1 / `rx_ready_i` in 1 — RX read handshake
- `rx_level_o`, `tx_level_o` out LW — FIFO occupancy
- `rx_overflow_o`, `tx_underrun_o` out 1 — sticky error flags
- `clear_i` in 1 — synchronous clear of sticky flags

## Operation
- Edge detect: `sc_q` registers `sample_clk_i` every cycle (regardless of `en_i`). A rise is `sample_clk_i & ~sc_q`; a fall is `~sample_clk_i & sc_q`. Slot events act only when `en_i = 1`.
- RX capture:
  - Fall: latch `adc_parallel_data_i` into `left_hold` and set `left_ok`.
  - Rise: if `left_ok`, push {`left_hold`, `adc_parallel_data_i`} into the RX FIFO and clear `left_ok`.
  - Rise with `left_ok = 0` (first rise after reset): no push.
- RX overflow: a push arriving while the RX FIFO is full, judged on occupancy at the start of the cycle, is dropped. `rx_overflow_o` is then set, even if a pop occurs in the same cycle.
- RX read: `rx_valid_o = ~empty`. The head pair is driven on `rx_left_o`/`rx_right_o`. A pop occurs when `rx_valid_o & rx_ready_i`. Outputs are 0 when empty.
- TX write: `tx_ready_o = ~full & ~rst_i`. A write occurs when `tx_valid_i & tx_ready_o`.
- TX pop:
  - Rise, FIFO non-empty: pop the head pair; `dac_parallel_data_o <= left`, `right_hold <= right`.
  - Rise, FIFO empty: `dac_parallel_data_o <= 0`, `right_hold <= 0`, set `tx_underrun_o`.
  - Fall: `dac_parallel_data_o <= right_hold`.
- Channel order is therefore never misaligned by underrun.
- FIFO occupancy:
  - Simultaneous push and pop on a non-empty, non-full FIFO: level unchanged, both take effect.
  - Simultaneous pop and push on an empty FIFO: not possible (pop requires non-empty).
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH; level is tracked in LW bits (0..DEPTH).
- `clear_i`: clears both sticky flags on that edge. If an error event occurs in the same cycle, set wins.
- `en_i = 0`: no captures, pops or underrun flagging. `sc_q` still tracks, so re-enabling never produces a stale edge. `left_ok` is retained.

## Timing
- Reset (async assert, sync-safe release): all outputs 0, including `tx_ready_o`. FIFOs empty; `left_hold`, `right_hold`, `left_ok` and `sc_q` are 0.
- Edge latency:
  - A level change on `sample_clk_i` seen at posedge k is acted on at posedge k.
  - `dac_parallel_data_o` is valid from k onward.
  - An RX push at k gives `rx_valid_o = 1` and level+1 visible after k.
- `adc_parallel_data_i` must be stable at the posedge where the edge is detected.
- TX write at posedge k makes the pair poppable by a rise detected at k+1 or later.
- Throughput: one push and one pop per FIFO per cycle. Slot events occur at most once per cycle.
- Reset mid-operation: all queued data is lost and outputs go to 0 immediately (asynchronous). The first rise after release produces no RX push.

## Test plan
- **TX basic:** reset, write pairs (0x111111, 0x222222) and (0x333333, 0x444444), then toggle `sample_clk_i` high/low twice. `dac_parallel_data_o` must show 0x111111, 0x222222, 0x333333, 0x444444; `tx_underrun_o` stays 0.
- **TX underrun:** with the TX FIFO empty, apply a rise. `dac_parallel_data_o = 0`, `tx_underrun_o = 1`, and 0 again on the following fall. Then pulse `clear_i`: the flag drops to 0.
- **RX pairing:**
  - After reset, apply a rise with ADC = 0xAAAAAA: no push.
  - Fall with 0x123456, then rise with 0x654321: `rx_valid_o = 1` with `rx_left_o = 0x123456`, `rx_right_o = 0x654321`.
- **RX overflow:** hold `rx_ready_i = 0` and run DEPTH+1 frames. `rx_level_o = 8`, `rx_overflow_o = 1`, and the head is still frame 1. Drain all 8 in order.
- **Full/wrap:** fill the TX FIFO to 8; check `tx_ready_o = 0`. Perform a simultaneous write and pop at level 4; level stays 4. Run 20 pairs through to check pointer wrap with data order preserved.
- **Enable/reset:**
  - With `en_i = 0`, toggle `sample_clk_i`: no pops, no pushes, no flags.
  - Assert `rst_i` mid-frame: outputs and levels are 0 immediately.
